// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute/memory/commit sequencer for the RV32I core; owns PC, IR and data latch.
// Optional retired-instruction counter output instret_out is enabled with the SEQ_INSTRET_EN macro.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        mem_valid_out,
  input  logic        mem_ready_in,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  input  logic [31:0] mem_rdata_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  input  logic [31:0] pc_next_in,
  input  logic [31:0] dmem_rd_addr_in,
  input  logic [31:0] dmem_wr_addr_in,
  input  logic [31:0] dmem_wr_data_in,
  output logic [31:0] dmem_rd_data_out,
  input  logic        reg_wr_en_in,
  output logic        reg_wr_en_out,
  output logic        retire_out,
  output logic        trap_out
`ifdef SEQ_INSTRET_EN
  ,
  output logic [63:0] instret_out
`endif
);

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rd_data;
  logic        is_store;
  logic        is_mem;
  logic        fetch_ok;

  assign is_store = (instr[6:0] == OP_STORE);
  assign is_mem   = is_store || (instr[6:0] == OP_LOAD);
  assign fetch_ok = (pc[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= S_RST;
      pc      <= RESET_PC;
      instr   <= 32'h0;
      rd_data <= 32'h0;
    end else begin
      case (state)
        S_RST:    state <= S_FETCH;
        S_FETCH: begin
          if (!fetch_ok) begin
            state <= S_TRAP;
          end else if (mem_ready_in) begin
            instr <= mem_rdata_in;
            state <= S_EXEC;
          end
        end
        S_EXEC:   state <= is_mem ? S_MEM_RD : S_COMMIT;
        S_MEM_RD: begin
          if (mem_ready_in) begin
            rd_data <= mem_rdata_in;
            state   <= is_store ? S_MEM_WR : S_COMMIT;
          end
        end
        S_MEM_WR: if (mem_ready_in) state <= S_COMMIT;
        S_COMMIT: begin
          pc    <= pc_next_in;
          state <= S_FETCH;
        end
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_RST;
      endcase
    end
  end

  // Bus outputs decode from state/registers only; mem_ready_in never reaches an output.
  always_comb begin
    mem_valid_out = 1'b0;
    mem_we_out    = 1'b0;
    mem_addr_out  = 32'h0;
    mem_wdata_out = 32'h0;
    case (state)
      S_FETCH: begin
        if (fetch_ok) begin
          mem_valid_out = 1'b1;
          mem_addr_out  = pc;
        end
      end
      S_MEM_RD: begin
        mem_valid_out = 1'b1;
        mem_addr_out  = dmem_rd_addr_in;
      end
      S_MEM_WR: begin
        mem_valid_out = 1'b1;
        mem_we_out    = 1'b1;
        mem_addr_out  = dmem_wr_addr_in;
        mem_wdata_out = dmem_wr_data_in;
      end
      default: ;
    endcase
  end

  assign pc_out           = pc;
  assign instr_out        = instr;
  assign dmem_rd_data_out = rd_data;
  assign retire_out       = (state == S_COMMIT);
  assign reg_wr_en_out    = (state == S_COMMIT) && reg_wr_en_in;
  assign trap_out         = (state == S_TRAP);

`ifdef SEQ_INSTRET_EN
  always_ff @(posedge clk) begin
    if (!nrst) instret_out <= 64'h0;
    else if (state == S_COMMIT) instret_out <= instret_out + 64'd1;
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: an instruction-level model predicts bus traffic and commits.
module tb_core_sequencer;
  localparam logic [31:0] RST_PC = 32'h100;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [31:0] pc_next;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic        wen;
    logic [1:0]  kind;
    logic [31:0] ld_val;
  } rec_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc, instr, pc_next, rd_addr, wr_addr, wr_data, rd_data;
  logic        reg_wen_in, reg_wen, retire, trap;
`ifdef SEQ_INSTRET_EN
  logic [63:0] instret;
`endif

  core_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .nrst(nrst),
    .mem_valid_out(mem_valid), .mem_ready_in(mem_ready), .mem_we_out(mem_we),
    .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata),
    .pc_out(pc), .instr_out(instr), .pc_next_in(pc_next),
    .dmem_rd_addr_in(rd_addr), .dmem_wr_addr_in(wr_addr), .dmem_wr_data_in(wr_data),
    .dmem_rd_data_out(rd_data), .reg_wr_en_in(reg_wen_in), .reg_wr_en_out(reg_wen),
    .retire_out(retire), .trap_out(trap)
`ifdef SEQ_INSTRET_EN
    , .instret_out(instret)
`endif
  );

  logic [31:0] image [256];
  logic [31:0] mem   [256];
  logic [31:0] mm    [256];
  rec_t        rec_arr [256];
  int          n_rec = 0;
  bus_t        bus_q [$];
  rec_t        com_q [$];
  logic        exp_trap = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          rmode = 0;
  logic        load_req = 1'b0;
  logic        nrst_q = 1'b0;
  int          cur = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expand(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs2,
                                        input logic [11:0] imm);
    return {imm[11:5], rs2, 5'd0, f3, imm[4:0], 7'b0100011};
  endfunction

  // Memory: combinational read, write on completed write transfer.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (load_req) mem <= image;
    else if (nrst && mem_valid && mem_ready && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  always @(posedge clk) begin
    nrst_q <= nrst;
    if (!nrst) cur <= 0;
    else if (retire) cur <= cur + 1;
  end

  // Decoder stand-in: replays the model's per-instruction decode, merging against the DUT's latched word.
  rec_t        sr;
  logic [31:0] bm;
  always_comb begin
    sr = '0;
    if (cur < n_rec) sr = rec_arr[cur[7:0]];
    bm         = expand(sr.st_mask);
    pc_next    = sr.pc_next;
    rd_addr    = sr.rd_addr;
    wr_addr    = sr.wr_addr;
    wr_data    = (rd_data & ~bm) | (sr.st_data & bm);
    reg_wen_in = sr.wen;
  end

  int   held = 0;
  logic done = 1'b0;
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (done) held = 0;
      if (mem_valid) begin
        case (rmode)
          0:       mem_ready = 1'b1;
          1:       mem_ready = (held >= 2);
          default: mem_ready = ($urandom_range(0, 2) == 0);
        endcase
        held++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        held = 0;
      end
      done = mem_valid && mem_ready;
    end
  end

  int          cyc = 0;
  int          waits = 0;
  logic        pend = 1'b0;
  logic [64:0] p_bus;
  bus_t        b;
  rec_t        r;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!nrst_q) begin
        cyc = 0; waits = 0; pend = 1'b0;
      end else begin
        cyc++;
        if (pend) check("hold_req", {mem_valid, mem_we, mem_addr, mem_wdata}, {1'b1, p_bus});
        if (mem_valid && !mem_ready) waits++;
        if (mem_valid && mem_ready) begin
          if (bus_q.size() == 0) begin
            check("extra_req", {mem_we, mem_addr}, 64'h0);
            check("extra_req_seen", 1'b1, 1'b0);
          end else begin
            b = bus_q.pop_front();
            check("req_addr_we", {mem_we, mem_addr}, {b.we, b.addr});
            if (b.we) check("req_wdata", mem_wdata, b.wdata);
          end
        end
        pend  = mem_valid && !mem_ready;
        p_bus = {mem_we, mem_addr, mem_wdata};
        if (!retire && reg_wen) check("wen_outside_commit", reg_wen, 1'b0);
        if (retire) begin
          if (com_q.size() == 0) begin
            check("extra_retire", retire, 1'b0);
          end else begin
            r = com_q.pop_front();
            check("reg_wen", reg_wen, r.wen);
            check("instr_cycles", cyc, 3 + ((r.kind == 2'd1) ? 1 : 0) + ((r.kind == 2'd2) ? 2 : 0) + waits);
            if (r.kind != 2'd0) check("data_latch", rd_data, r.ld_val);
          end
          cyc = 0; waits = 0;
        end
        if (trap) check("trap_quiet", {mem_valid, retire, reg_wen}, 3'b000);
      end
    end
  end

  task automatic predict();
    logic [31:0] regs [32];
    logic [31:0] p, ins, a, v, m, nw, imm_i, imm_s;
    logic [4:0]  rd;
    rec_t        q;
    foreach (regs[i]) regs[i] = 32'h0;
    mm = image;
    n_rec = 0;
    bus_q.delete();
    com_q.delete();
    exp_trap = 1'b0;
    p = RST_PC;
    for (int n = 0; n < 200; n++) begin
      if (p[1:0] != 2'b00) begin
        exp_trap = 1'b1;
        break;
      end
      ins = mm[p[9:2]];
      bus_q.push_back('{p, 1'b0, 32'h0});
      q = '0;
      q.pc_next = p + 32'd4;
      rd = ins[11:7];
      imm_i = {{20{ins[31]}}, ins[31:20]};
      imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      case (ins[6:0])
        7'b0010011: begin
          q.wen = (rd != 5'd0);
          v = regs[ins[19:15]] + imm_i;
          if (rd != 5'd0) regs[rd] = v;
        end
        7'b0110111: begin
          q.wen = (rd != 5'd0);
          if (rd != 5'd0) regs[rd] = {ins[31:12], 12'h0};
        end
        7'b0000011: begin
          a = regs[ins[19:15]] + imm_i;
          q.kind = 2'd1;
          q.rd_addr = a;
          q.ld_val = mm[a[9:2]];
          q.wen = (rd != 5'd0);
          bus_q.push_back('{a, 1'b0, 32'h0});
          if (rd != 5'd0) regs[rd] = q.ld_val;
        end
        7'b0100011: begin
          a = regs[ins[19:15]] + imm_s;
          v = regs[ins[24:20]];
          q.kind = 2'd2;
          q.rd_addr = {a[31:2], 2'b00};
          q.wr_addr = {a[31:2], 2'b00};
          q.ld_val = mm[a[9:2]];
          if (ins[14:12] == 3'd0) begin
            q.st_mask = 4'b0001 << a[1:0];
            q.st_data = {4{v[7:0]}};
          end else begin
            q.st_mask = 4'hF;
            q.st_data = v;
          end
          m = expand(q.st_mask);
          nw = (q.ld_val & ~m) | (q.st_data & m);
          mm[a[9:2]] = nw;
          bus_q.push_back('{q.rd_addr, 1'b0, 32'h0});
          bus_q.push_back('{q.wr_addr, 1'b1, nw});
        end
        7'b1100111: begin
          q.pc_next = (regs[ins[19:15]] + imm_i) & ~32'd1;
          q.wen = (rd != 5'd0);
          if (rd != 5'd0) regs[rd] = p + 32'd4;
        end
        default: ;
      endcase
      rec_arr[n_rec[7:0]] = q;
      n_rec++;
      com_q.push_back(q);
      p = q.pc_next;
    end
  endtask

  task automatic gen_directed();
    for (int i = 0; i < 256; i++) image[i] = (i < 64) ? $urandom() : 32'h0;
    image[1]  = 32'hDEADBEEF;
    image[2]  = 32'h11223344;
    image[64] = 32'h00500093;
    image[65] = enc_i(7'b0000011, 5'd2, 3'd2, 5'd0, 12'd4);
    image[66] = enc_i(7'b0010011, 5'd3, 3'd0, 5'd0, 12'h0AA);
    image[67] = enc_s(3'd0, 5'd3, 12'd8);
    image[68] = enc_i(7'b1100111, 5'd0, 3'd0, 5'd0, 12'h118);
    image[69] = enc_s(3'd2, 5'd1, 12'd0);
    image[70] = enc_i(7'b1100111, 5'd0, 3'd0, 5'd0, 12'h102);
  endtask

  task automatic gen_random();
    int k;
    logic [31:0] t;
    for (int i = 0; i < 256; i++) image[i] = (i < 64) ? $urandom() : 32'h0;
    k = 0;
    while (k < 24) begin
      t = RST_PC + 32'(4 * k) + 32'd8;
      case ($urandom_range(0, 5))
        0: image[64+k] = enc_i(7'b0010011, 5'($urandom_range(0, 7)), 3'd0, 5'($urandom_range(0, 7)), 12'($urandom()));
        1: image[64+k] = {20'($urandom()), 5'($urandom_range(0, 7)), 7'b0110111};
        2: image[64+k] = enc_i(7'b0000011, 5'($urandom_range(0, 7)), 3'd2, 5'd0, 12'($urandom_range(0, 63) * 4));
        3: image[64+k] = enc_s(3'd2, 5'($urandom_range(0, 7)), 12'($urandom_range(0, 63) * 4));
        4: image[64+k] = enc_s(3'd0, 5'($urandom_range(0, 7)), 12'($urandom_range(0, 255)));
        default: begin
          image[64+k] = enc_i(7'b1100111, 5'($urandom_range(0, 7)), 3'd0, 5'd0, t[11:0]);
          k++;
          image[64+k] = enc_i(7'b0010011, 5'd6, 3'd0, 5'd0, 12'h7FF);
        end
      endcase
      k++;
    end
    image[64+k] = enc_i(7'b1100111, 5'd0, 3'd0, 5'd0, 12'h102 + 12'(4 * $urandom_range(0, 3)));
  endtask

  task automatic start_reset();
    @(negedge clk);
    nrst = 1'b0;
    load_req = 1'b1;
    predict();
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    #2;
  endtask

  task automatic run_prog(input int mode);
    int t;
    rmode = mode;
    start_reset();
    check("rst_bus", {mem_valid, mem_we, mem_addr, mem_wdata}, 65'h0);
    check("rst_pc", pc, RST_PC);
    check("rst_instr_data", {instr, rd_data}, 64'h0);
    check("rst_flags", {reg_wen, retire, trap}, 3'b000);
`ifdef SEQ_INSTRET_EN
    check("rst_instret", instret, 64'h0);
`endif
    nrst = 1'b1;
    @(negedge clk);
    #2;
    check("first_req", {mem_valid, mem_we, mem_addr}, {1'b1, 1'b0, RST_PC});
    t = 0;
    while (!trap && t < 3000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("trap_reached", trap, exp_trap);
    repeat (4) @(negedge clk);
    #2;
    check("trap_sticky", trap, 1'b1);
    check("bus_left", bus_q.size(), 0);
    check("commits_left", com_q.size(), 0);
`ifdef SEQ_INSTRET_EN
    check("instret", instret, 64'(n_rec));
`endif
  endtask

  task automatic reset_mid();
    int   t;
    logic hit;
    rmode = 1;
    start_reset();
    nrst = 1'b1;
    t = 0;
    hit = 1'b0;
    while (!hit && t < 500) begin
      @(negedge clk);
      #2;
      t++;
      hit = mem_valid && mem_we && !mem_ready;
    end
    check("mem_wr_wait_reached", hit, 1'b1);
    nrst = 1'b0;
    @(negedge clk);
    #2;
    check("abort_bus", {mem_valid, mem_we, mem_addr}, 33'h0);
    check("abort_flags", {retire, reg_wen, trap}, 3'b000);
    check("abort_pc", pc, RST_PC);
    check("abandoned_write", mem[2], 32'h11223344);
`ifdef SEQ_INSTRET_EN
    check("abort_instret", instret, 64'h0);
`endif
  endtask

  initial begin
    gen_directed();
    run_prog(0);
    run_prog(1);
    for (int s = 0; s < 3; s++) begin
      gen_random();
      run_prog(2);
    end
    gen_random();
    run_prog(0);
    gen_directed();
    reset_mid();
    run_prog(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
